// File: rtl/fp_sub_seq.sv
// Iterative single-precision subtractor (out = A - B): one alignment shift and one
// normalization shift per cycle instead of barrel shifters, with a start/done handshake.
module fp_sub_seq #(
  parameter int ALIGN_LIMIT = 25,
  parameter bit FTZ         = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] out,
  output logic        ovf,
  output logic        unf
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

  localparam logic [7:0] LIMIT = 8'(ALIGN_LIMIT);

  state_t      state, state_nx;
  logic        big_s, small_s, res_s, ovf_pend;
  logic [23:0] big_m, small_m;
  logic [8:0]  exp_r;
  logic [7:0]  diff;
  logic [24:0] sum, add_raw;
  logic        add_s;

  logic       a_zero, b_zero, a_ge, align_last, norm_last;
  logic [7:0] exp_diff;

  assign a_zero     = (A[30:23] == 8'd0);
  assign b_zero     = (B[30:23] == 8'd0);
  assign a_ge       = (A[30:23] >= B[30:23]);
  assign exp_diff   = a_ge ? (A[30:23] - B[30:23]) : (B[30:23] - A[30:23]);
  assign align_last = (diff >= LIMIT) || (diff == 8'd1);
  assign norm_last  = ovf_pend || (sum == 25'd0) || sum[23] || (exp_r == 9'd1);

  // Signed-magnitude add; the operand with the larger magnitude supplies the sign.
  always_comb begin
    add_raw = 25'd0;
    add_s   = big_s;
    if (big_s == small_s) begin
      add_raw = {1'b0, big_m} + {1'b0, small_m};
    end else if (big_m >= small_m) begin
      add_raw = {1'b0, big_m} - {1'b0, small_m};
    end else begin
      add_raw = {1'b0, small_m} - {1'b0, big_m};
      add_s   = small_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (a_zero || b_zero) ? DONE :
                                     (exp_diff == 8'd0) ? ADD : ALIGN;
      ALIGN:   if (align_last) state_nx = ADD;
      ADD:     state_nx = NORM;
      NORM:    if (norm_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out      <= 32'd0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
      big_s    <= 1'b0;
      small_s  <= 1'b0;
      res_s    <= 1'b0;
      ovf_pend <= 1'b0;
      big_m    <= 24'd0;
      small_m  <= 24'd0;
      exp_r    <= 9'd0;
      diff     <= 8'd0;
      sum      <= 25'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          if (a_zero || b_zero) begin
            if (a_zero && b_zero) out <= 32'd0;
            else if (a_zero)      out <= {~B[31], B[30:0]};
            else                  out <= A;
            ovf <= 1'b0;
            unf <= 1'b0;
          end else begin
            // B enters with its sign flipped so the rest of the datapath only adds.
            if (a_ge) begin
              big_s   <= A[31];
              big_m   <= {1'b1, A[22:0]};
              small_s <= ~B[31];
              small_m <= {1'b1, B[22:0]};
              exp_r   <= {1'b0, A[30:23]};
            end else begin
              big_s   <= ~B[31];
              big_m   <= {1'b1, B[22:0]};
              small_s <= A[31];
              small_m <= {1'b1, A[22:0]};
              exp_r   <= {1'b0, B[30:23]};
            end
            diff     <= exp_diff;
            ovf_pend <= 1'b0;
          end
        end
        ALIGN: begin
          if (diff >= LIMIT) begin
            small_m <= 24'd0;
            diff    <= 8'd0;
          end else begin
            small_m <= small_m >> 1;
            diff    <= diff - 8'd1;
          end
        end
        ADD: begin
          res_s <= add_s;
          if (add_raw[24]) begin
            sum      <= add_raw >> 1;
            exp_r    <= exp_r + 9'd1;
            ovf_pend <= ((exp_r + 9'd1) > 9'd254);
          end else begin
            sum <= add_raw;
          end
        end
        NORM: begin
          if (ovf_pend) begin
            out <= {res_s, 8'hFE, 23'h7FFFFF};
            ovf <= 1'b1;
            unf <= 1'b0;
          end else if (sum == 25'd0) begin
            out <= 32'd0;
            ovf <= 1'b0;
            unf <= 1'b0;
          end else if (sum[23]) begin
            out <= {res_s, exp_r[7:0], sum[22:0]};
            ovf <= 1'b0;
            unf <= 1'b0;
          end else if (exp_r == 9'd1) begin
            out <= FTZ ? 32'd0 : {res_s, 8'h01, sum[22:0]};
            ovf <= 1'b0;
            unf <= 1'b1;
          end else begin
            sum   <= sum << 1;
            exp_r <= exp_r - 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
